sport1_link_partner: RTL and testbench

//  Serial link partner for the SPORT1 serial port: the far-end codec side of the SCLK/TFS/DT/RFS/DR wires.
//  - Deserialises words the SPORT transmits on TDx (TFS-framed) into an RX FIFO.
//  - Serialises words from a TX FIFO onto the SPORT's RDx pin (RFS-framed).
//  - SPORT is clock/frame master (internal SCLK, ITFS/IRFS); this block is slave, clocked by DSPCLK.

---
 rtl/sport1_link_partner_if.sv | 34 +++
 rtl/sport1_link_partner.sv | 223 ++++++++++++++++++++++
 tb/tb_sport1_link_partner.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sport1_link_partner_if.sv
// Purpose : bundles the SPORT1 serial pins and the host-side FIFO/flag signals of the link partner.
// Latency : none (wires only).
// Backpr. : none here; TXFULL/RXV carry FIFO state to the host.
// Modports: slave = the link partner itself, master = the SPORT/host environment driving it.
// Option  : SPLP_LOOPBACK_EN adds LPBK.
interface sport1_link_partner_if;
    logic        SCLK;
    logic        TFS;
    logic        DT;
    logic        RFS;
    logic        DR;
    logic [15:0] RXD;
    logic        RXV;
    logic        RXPOP;
    logic [15:0] TXD;
    logic        TXPUSH;
    logic        TXFULL;
    logic        OVR;
    logic        UNR;
    logic        STCLR;
`ifdef SPLP_LOOPBACK_EN
    logic        LPBK;

    modport slave  (input  SCLK, TFS, DT, RFS, RXPOP, TXD, TXPUSH, STCLR, LPBK,
                    output DR, RXD, RXV, TXFULL, OVR, UNR);
    modport master (output SCLK, TFS, DT, RFS, RXPOP, TXD, TXPUSH, STCLR, LPBK,
                    input  DR, RXD, RXV, TXFULL, OVR, UNR);
`else
    modport slave  (input  SCLK, TFS, DT, RFS, RXPOP, TXD, TXPUSH, STCLR,
                    output DR, RXD, RXV, TXFULL, OVR, UNR);
    modport master (output SCLK, TFS, DT, RFS, RXPOP, TXD, TXPUSH, STCLR,
                    input  DR, RXD, RXV, TXFULL, OVR, UNR);
`endif
endinterface

// File: rtl/sport1_link_partner.sv
// Purpose : SPORT1 far-end codec: deserialises TFS-framed DT words into an RX FIFO and serialises
//           TX FIFO words onto DR in RFS-framed slots; SPORT is clock/frame master.
// Latency : pins pass a 2-flop sync; a received word shows on RXV two DSPCLK after its last fall is seen.
// Backpr. : full RX FIFO drops the word and sets OVR; empty TX FIFO at frame start sends zeros, sets UNR.
// Ports   : DSPCLK, RSTn (async active-low); lp (slave modport): SCLK/TFS/DT/RFS/DR serial pins,
//           RXD/RXV/RXPOP RX head, TXD/TXPUSH/TXFULL TX tail, OVR/UNR sticky flags cleared by STCLR.
// Option  : define SPLP_LOOPBACK_EN to add lp.LPBK, echoing each completed RX word into the TX FIFO.

// Purpose : small synchronous FIFO with wrap-bit pointers, head word shown combinationally.
// Latency : a push is visible at the head the cycle after it is written.
// Backpr. : push while full is dropped unless a pop happens in the same cycle.
module sport1_link_partner_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         pop_ok, push_ok;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers mask its content.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

module sport1_link_partner #(
    parameter int WLEN   = 16,
    parameter int FDEPTH = 4
) (
    input logic                  DSPCLK,
    input logic                  RSTn,
    sport1_link_partner_if.slave lp
);
    localparam int CW = $clog2(WLEN + 1);

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic            sclk_last_q, sclk_last_d;
    logic            sfall, srise, tfs_s, dt_s, rfs_s;

    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [WLEN-1:0] rx_sh_q, rx_sh_d;
    logic            rx_wr_q, rx_wr_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [WLEN-1:0] tx_sh_q, tx_sh_d;
    logic            dr_q, dr_d;

    logic            ovr_q, ovr_d, unr_q, unr_d;
    logic            ovr_set, unr_set, tx_pop, tx_push;
    logic            rx_empty, rx_full, tx_empty, tx_full;
    logic [WLEN-1:0] rx_head, tx_head, tx_push_dat;

    // Pin synchronisers; SCLK edges are detected after the second stage so
    // the data/frame pins are always sampled at the same depth as the clock.
    always_comb begin
        sync1_d     = {lp.SCLK, lp.TFS, lp.DT, lp.RFS};
        sync2_d     = sync1_q;
        sclk_last_d = sync2_q[3];
        tfs_s       = sync2_q[2];
        dt_s        = sync2_q[1];
        rfs_s       = sync2_q[0];
        sfall       = sclk_last_q && !sync2_q[3];
        srise       = !sclk_last_q && sync2_q[3];
    end

    // RX: frame sync on a fall, then WLEN data captures on the following falls.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_wr_d    = 1'b0;
        if (sfall) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (tfs_s) begin
                        rx_state_d = RX_SHIFT;
                        rx_cnt_d   = '0;
                    end
                end
                default: begin
                    rx_sh_d = {rx_sh_q[WLEN-2:0], dt_s};
                    if (rx_cnt_q == CW'(WLEN - 1)) begin
                        // Last bit: TFS seen on this same fall frames the next word.
                        rx_wr_d    = 1'b1;
                        rx_cnt_d   = '0;
                        rx_state_d = tfs_s ? RX_SHIFT : RX_IDLE;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            endcase
        end
        // The shift register holds the finished word for the write cycle: the
        // next fall is at least two DSPCLK away.
        ovr_set = rx_wr_q && rx_full && !lp.RXPOP;
    end

    // TX: tx_cnt == WLEN is the tail where DR still holds the LSB; a frame
    // sync there reloads immediately so consecutive words have no gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        dr_d       = dr_q;
        tx_pop     = 1'b0;
        unr_set    = 1'b0;
        if (sfall && rfs_s && (tx_state_q == TX_IDLE || tx_cnt_q == CW'(WLEN))) begin
            tx_pop     = !tx_empty;
            unr_set    = tx_empty;
            tx_sh_d    = tx_empty ? '0 : tx_head;
            tx_cnt_d   = '0;
            tx_state_d = TX_SHIFT;
        end else if (srise && tx_state_q == TX_SHIFT) begin
            if (tx_cnt_q == CW'(WLEN)) begin
                dr_d       = 1'b0;
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
            end else begin
                dr_d     = tx_sh_q[WLEN-1];
                tx_sh_d  = {tx_sh_q[WLEN-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
        end
`ifdef SPLP_LOOPBACK_EN
        tx_push     = lp.LPBK ? rx_wr_q : lp.TXPUSH;
        tx_push_dat = lp.LPBK ? rx_sh_q : lp.TXD[WLEN-1:0];
`else
        tx_push     = lp.TXPUSH;
        tx_push_dat = lp.TXD[WLEN-1:0];
`endif
    end

    // Sticky flags: a set in the same cycle as STCLR wins.
    always_comb begin
        ovr_d = lp.STCLR ? 1'b0 : ovr_q;
        unr_d = lp.STCLR ? 1'b0 : unr_q;
        if (ovr_set) ovr_d = 1'b1;
        if (unr_set) unr_d = 1'b1;
    end

    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sclk_last_q <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_sh_q     <= '0;
            rx_wr_q     <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_sh_q     <= '0;
            dr_q        <= 1'b0;
            ovr_q       <= 1'b0;
            unr_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sclk_last_q <= sclk_last_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_wr_q     <= rx_wr_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_sh_q     <= tx_sh_d;
            dr_q        <= dr_d;
            ovr_q       <= ovr_d;
            unr_q       <= unr_d;
        end
    end

    sport1_link_partner_fifo #(.W(WLEN), .DEPTH(FDEPTH)) u_rx_fifo (
        .clk(DSPCLK), .rst_n(RSTn), .push(rx_wr_q), .push_dat(rx_sh_q),
        .pop(lp.RXPOP), .head_dat(rx_head), .empty(rx_empty), .full(rx_full));

    sport1_link_partner_fifo #(.W(WLEN), .DEPTH(FDEPTH)) u_tx_fifo (
        .clk(DSPCLK), .rst_n(RSTn), .push(tx_push), .push_dat(tx_push_dat),
        .pop(tx_pop), .head_dat(tx_head), .empty(tx_empty), .full(tx_full));

    assign lp.DR     = dr_q;
    assign lp.RXD    = 16'(rx_head);
    assign lp.RXV    = !rx_empty;
    assign lp.TXFULL = tx_full;
    assign lp.OVR    = ovr_q;
    assign lp.UNR    = unr_q;
endmodule

// File: tb/tb_sport1_link_partner.sv
// Bench for sport1_link_partner: plays the SPORT (SCLK master, TFS/RFS framing, DR sampling on
// falls) and the host (FIFO push/pop, STCLR), comparing against queue-based expectations.
module tb_sport1_link_partner;
    localparam int WLEN   = 16;
    localparam int FDEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] got_w [8];
    logic        dr_after;
    logic [15:0] rxq [$];
    logic [15:0] txq [$];
    logic        m_ovr, m_unr;

    sport1_link_partner_if lp();

    sport1_link_partner #(.WLEN(WLEN), .FDEPTH(FDEPTH)) dut (
        .DSPCLK(clk),
        .RSTn  (rst_n),
        .lp    (lp)
    );

    always #5 clk = ~clk;

    // SCLK = DSPCLK/8, offset so its edges never coincide with DSPCLK edges.
    initial begin
        lp.SCLK = 1'b0;
        #2;
        forever #40 lp.SCLK = ~lp.SCLK;
    end

    // SPORT transmit: TFS for one bit time, then WLEN bits MSB first, changed on rises.
    task automatic send_frame(input logic [15:0] w, input int nbits);
        @(posedge lp.SCLK); lp.TFS = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            @(posedge lp.SCLK); lp.TFS = 1'b0; lp.DT = w[WLEN-1-i];
        end
        @(posedge lp.SCLK); lp.DT = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // SPORT receive: n RFS frames back to back, DR sampled on falls.
    task automatic tx_frames(input int n);
        @(posedge lp.SCLK); lp.RFS = 1'b1;
        for (int f = 0; f < n; f++) begin
            got_w[f] = '0;
            for (int i = 0; i < WLEN; i++) begin
                @(posedge lp.SCLK); lp.RFS = (i == WLEN-1) && (f < n-1);
                @(negedge lp.SCLK); got_w[f] = {got_w[f][14:0], lp.DR};
            end
        end
        @(posedge lp.SCLK);
        @(negedge lp.SCLK); dr_after = lp.DR;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_tx(input logic [15:0] w);
        @(negedge clk); lp.TXD = w; lp.TXPUSH = 1'b1;
        @(negedge clk); lp.TXPUSH = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk); lp.RXPOP = 1'b1;
        @(negedge clk); lp.RXPOP = 1'b0;
    endtask

    task automatic stclr();
        @(negedge clk); lp.STCLR = 1'b1;
        @(negedge clk); lp.STCLR = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (lp.DR !== 1'b0)     begin bad++; $display("FAIL reset_dr got=%b exp=0", lp.DR); end
        total++; if (lp.RXV !== 1'b0)    begin bad++; $display("FAIL reset_rxv got=%b exp=0", lp.RXV); end
        total++; if (lp.RXD !== 16'h0)   begin bad++; $display("FAIL reset_rxd got=%h exp=0000", lp.RXD); end
        total++; if (lp.TXFULL !== 1'b0) begin bad++; $display("FAIL reset_txfull got=%b exp=0", lp.TXFULL); end
        total++; if (lp.OVR !== 1'b0)    begin bad++; $display("FAIL reset_ovr got=%b exp=0", lp.OVR); end
        total++; if (lp.UNR !== 1'b0)    begin bad++; $display("FAIL reset_unr got=%b exp=0", lp.UNR); end
        rst_n = 1'b1;
        repeat (4) @(posedge lp.SCLK);
        @(negedge clk);
        total++; if (lp.RXV !== 1'b0)    begin bad++; $display("FAIL idle_rxv got=%b exp=0", lp.RXV); end
    endtask

    task automatic test_rx_basic();
        send_frame(16'hA5C3, WLEN);
        total++; if (lp.RXV !== 1'b1)     begin bad++; $display("FAIL rx_basic_rxv got=%b exp=1", lp.RXV); end
        total++; if (lp.RXD !== 16'hA5C3) begin bad++; $display("FAIL rx_basic_rxd got=%h exp=a5c3", lp.RXD); end
        pop_rx();
        total++; if (lp.RXV !== 1'b0)     begin bad++; $display("FAIL rx_basic_pop_rxv got=%b exp=0", lp.RXV); end
    endtask

    task automatic test_tx_basic();
        logic [15:0] exp_w;
        exp_w = 16'h1234;
        push_tx(exp_w);
        tx_frames(1);
        for (int i = 0; i < WLEN; i++) begin
            total++;
            if (got_w[0][WLEN-1-i] !== exp_w[WLEN-1-i]) begin
                bad++; $display("FAIL tx_basic_bit%0d got=%b exp=%b", i, got_w[0][WLEN-1-i], exp_w[WLEN-1-i]);
            end
        end
        total++; if (dr_after !== 1'b0) begin bad++; $display("FAIL tx_basic_dr_after got=%b exp=0", dr_after); end
        total++; if (lp.UNR !== 1'b0)   begin bad++; $display("FAIL tx_basic_unr got=%b exp=0", lp.UNR); end
    endtask

    task automatic test_overflow();
        logic [15:0] w [5];
        for (int k = 0; k < 5; k++) begin
            w[k] = 16'($urandom);
            send_frame(w[k], WLEN);
            if (k == FDEPTH-1) begin
                total++; if (lp.OVR !== 1'b0) begin bad++; $display("FAIL ovr_at_full got=%b exp=0", lp.OVR); end
            end
        end
        total++; if (lp.OVR !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", lp.OVR); end
        for (int k = 0; k < FDEPTH; k++) begin
            total++; if (lp.RXV !== 1'b1) begin bad++; $display("FAIL ovr_rxv%0d got=%b exp=1", k, lp.RXV); end
            total++; if (lp.RXD !== w[k]) begin bad++; $display("FAIL ovr_rxd%0d got=%h exp=%h", k, lp.RXD, w[k]); end
            pop_rx();
        end
        total++; if (lp.RXV !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b exp=0", lp.RXV); end
        stclr();
        total++; if (lp.OVR !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", lp.OVR); end
    endtask

    task automatic test_underrun();
        tx_frames(1);
        total++; if (got_w[0] !== 16'h0) begin bad++; $display("FAIL unr_word got=%h exp=0000", got_w[0]); end
        total++; if (lp.UNR !== 1'b1)    begin bad++; $display("FAIL unr_set got=%b exp=1", lp.UNR); end
        stclr();
        total++; if (lp.UNR !== 1'b0)    begin bad++; $display("FAIL unr_clear got=%b exp=0", lp.UNR); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [FDEPTH];
        for (int k = 0; k < FDEPTH; k++) begin
            w[k] = 16'($urandom);
            push_tx(w[k]);
            total++;
            if (lp.TXFULL !== (k == FDEPTH-1)) begin
                bad++; $display("FAIL b2b_txfull%0d got=%b exp=%b", k, lp.TXFULL, (k == FDEPTH-1));
            end
        end
        push_tx(16'hDEAD);
        total++; if (lp.TXFULL !== 1'b1) begin bad++; $display("FAIL b2b_txfull_extra got=%b exp=1", lp.TXFULL); end
        tx_frames(FDEPTH);
        for (int k = 0; k < FDEPTH; k++) begin
            total++; if (got_w[k] !== w[k]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", k, got_w[k], w[k]); end
        end
        total++; if (dr_after !== 1'b0)  begin bad++; $display("FAIL b2b_dr_after got=%b exp=0", dr_after); end
        total++; if (lp.UNR !== 1'b0)    begin bad++; $display("FAIL b2b_unr got=%b exp=0", lp.UNR); end
        total++; if (lp.TXFULL !== 1'b0) begin bad++; $display("FAIL b2b_txfull_end got=%b exp=0", lp.TXFULL); end
    endtask

    task automatic test_reset_midframe();
        // DR must drop the moment reset asserts, not at the next clock.
        push_tx(16'hFFFF);
        @(posedge lp.SCLK); lp.RFS = 1'b1;
        @(posedge lp.SCLK); lp.RFS = 1'b0;
        @(negedge lp.SCLK);
        total++; if (lp.DR !== 1'b1) begin bad++; $display("FAIL midrst_dr_before got=%b exp=1", lp.DR); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (lp.DR !== 1'b0) begin bad++; $display("FAIL midrst_dr_async got=%b exp=0", lp.DR); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // RX frame cut after 7 bits, then a clean frame.
        send_frame(16'($urandom), 7);
        do_reset();
        total++; if (lp.RXV !== 1'b0)     begin bad++; $display("FAIL midrst_rxv got=%b exp=0", lp.RXV); end
        send_frame(16'h00FF, WLEN);
        total++; if (lp.RXV !== 1'b1)     begin bad++; $display("FAIL midrst_new_rxv got=%b exp=1", lp.RXV); end
        total++; if (lp.RXD !== 16'h00FF) begin bad++; $display("FAIL midrst_new_rxd got=%h exp=00ff", lp.RXD); end
        pop_rx();
        total++; if (lp.RXV !== 1'b0)     begin bad++; $display("FAIL midrst_only_one got=%b exp=0", lp.RXV); end
    endtask

`ifdef SPLP_LOOPBACK_EN
    task automatic test_loopback();
        lp.LPBK = 1'b1;
        push_tx(16'h1111);
        total++; if (lp.TXFULL !== 1'b0)  begin bad++; $display("FAIL lpbk_txpush_ignored got=%b exp=0", lp.TXFULL); end
        send_frame(16'hBEEF, WLEN);
        total++; if (lp.RXD !== 16'hBEEF) begin bad++; $display("FAIL lpbk_rxd got=%h exp=beef", lp.RXD); end
        pop_rx();
        tx_frames(1);
        total++; if (got_w[0] !== 16'hBEEF) begin bad++; $display("FAIL lpbk_echo got=%h exp=beef", got_w[0]); end
        total++; if (lp.UNR !== 1'b0)       begin bad++; $display("FAIL lpbk_unr got=%b exp=0", lp.UNR); end
        lp.LPBK = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [15:0] w, exp_w;
        int          op;
        do_reset();
        rxq.delete(); txq.delete();
        m_ovr = 1'b0; m_unr = 1'b0;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            w  = 16'($urandom);
            case (op)
                0: begin
                    send_frame(w, WLEN);
                    if (rxq.size() < FDEPTH) rxq.push_back(w);
                    else m_ovr = 1'b1;
                end
                1: begin
                    total++;
                    if (lp.RXV !== (rxq.size() != 0)) begin
                        bad++; $display("FAIL rnd_rxv it=%0d got=%b exp=%b", it, lp.RXV, (rxq.size() != 0));
                    end
                    if (rxq.size() != 0) begin
                        total++;
                        if (lp.RXD !== rxq[0]) begin bad++; $display("FAIL rnd_rxd it=%0d got=%h exp=%h", it, lp.RXD, rxq[0]); end
                        void'(rxq.pop_front());
                    end
                    pop_rx();
                end
                2: begin
                    total++;
                    if (lp.TXFULL !== (txq.size() == FDEPTH)) begin
                        bad++; $display("FAIL rnd_txfull it=%0d got=%b exp=%b", it, lp.TXFULL, (txq.size() == FDEPTH));
                    end
                    push_tx(w);
                    if (txq.size() < FDEPTH) txq.push_back(w);
                end
                default: begin
                    if (txq.size() != 0) exp_w = txq.pop_front();
                    else begin exp_w = '0; m_unr = 1'b1; end
                    tx_frames(1);
                    total++; if (got_w[0] !== exp_w) begin bad++; $display("FAIL rnd_dr it=%0d got=%h exp=%h", it, got_w[0], exp_w); end
                    total++; if (dr_after !== 1'b0)  begin bad++; $display("FAIL rnd_dr_after it=%0d got=%b exp=0", it, dr_after); end
                end
            endcase
            total++; if (lp.OVR !== m_ovr) begin bad++; $display("FAIL rnd_ovr it=%0d got=%b exp=%b", it, lp.OVR, m_ovr); end
            total++; if (lp.UNR !== m_unr) begin bad++; $display("FAIL rnd_unr it=%0d got=%b exp=%b", it, lp.UNR, m_unr); end
            if ($urandom_range(0, 7) == 0) begin
                stclr();
                m_ovr = 1'b0; m_unr = 1'b0;
            end
        end
    endtask

    initial begin
        lp.TFS = 1'b0; lp.DT = 1'b0; lp.RFS = 1'b0;
        lp.RXPOP = 1'b0; lp.TXD = '0; lp.TXPUSH = 1'b0; lp.STCLR = 1'b0;
`ifdef SPLP_LOOPBACK_EN
        lp.LPBK = 1'b0;
`endif
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_overflow();
        test_underrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef SPLP_LOOPBACK_EN
        test_loopback();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
